// File: rtl/cpe_pkg.sv
// ---------------------------------------------------------------------------
// cpe_pkg
// Shared definitions for the check-and-retry controller slice:
//   CW_W        codeword / syndrome width
//   ERRCNT_W    width of the optional saturating error counter
//   RETRY_W     width of the per-transaction retry counter
//   PARITY_POLY parity-check polynomial h(x) of the cyclic code; a codeword
//               c(x) is clean when c(x)*h(x) mod (x^15 + 1) is zero
//   state_t     controller FSM states
//   rotl_cw     cyclic left rotation of a codeword-wide vector
// ---------------------------------------------------------------------------
package cpe_pkg;

   localparam int CW_W     = 15;
   localparam int ERRCNT_W = 8;
   localparam int RETRY_W  = 4;

   // h(x) = 1 + x^4 + x^6 + x^7; generator is g(x) = 1 + x^4 + x^6 + x^7 + x^8
   localparam logic [CW_W-1:0] PARITY_POLY = 15'h00D1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      EVAL  = 3'd2,
      RETRY = 3'd3,
      OUT   = 3'd4
   } state_t;

   // Multiplying by x^n modulo (x^15 + 1) is a left rotation by n.
   function automatic logic [CW_W-1:0] rotl_cw(input logic [CW_W-1:0] v,
                                               input int unsigned     n);
      logic [2*CW_W-1:0] dbl;
      dbl = {v, v} << n;
      return dbl[2*CW_W-1 -: CW_W];
   endfunction

endpackage

// File: rtl/cpe_retry_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpe_retry_ctrl_if
// Handshake bundle between the CPE datapath, the retry controller and the
// downstream consumer.
//   in_valid / in_ready / in_cw       codeword from upstream
//   retry_req                         recompute request back to upstream
//   out_valid / out_ready             result handshake to downstream
//   out_cw / out_fatal / out_syndrome result payload
// Modports:
//   master  the environment (upstream + downstream side)
//   slave   the retry controller
// ---------------------------------------------------------------------------
interface cpe_retry_ctrl_if;

   logic                       in_valid;
   logic                       in_ready;
   logic [cpe_pkg::CW_W-1:0]   in_cw;
   logic                       retry_req;
   logic                       out_valid;
   logic                       out_ready;
   logic [cpe_pkg::CW_W-1:0]   out_cw;
   logic                       out_fatal;
   logic [cpe_pkg::CW_W-1:0]   out_syndrome;

   modport master (
      output in_valid,
      output in_cw,
      output out_ready,
      input  in_ready,
      input  retry_req,
      input  out_valid,
      input  out_cw,
      input  out_fatal,
      input  out_syndrome
   );

   modport slave (
      input  in_valid,
      input  in_cw,
      input  out_ready,
      output in_ready,
      output retry_req,
      output out_valid,
      output out_cw,
      output out_fatal,
      output out_syndrome
   );

endinterface

// File: rtl/cpe_retry_ctrl_detector.sv
// ---------------------------------------------------------------------------
// detector
// Combinational codeword detector for the (15,7) cyclic code.
//   c      in   codeword, bit 0 = c[0]
//   s      out  syndrome = c(x) * h(x) mod (x^15 + 1); zero for any codeword
//   error  out  syndrome is nonzero
// ---------------------------------------------------------------------------
module detector
   import cpe_pkg::*;
(
   input  logic [CW_W-1:0] c,
   output logic [CW_W-1:0] s,
   output logic            error
);

   // Each set bit i of c contributes h(x) * x^i, i.e. h rotated left by i.
   always_comb begin
      s = '0;
      for (int i = 0; i < CW_W; i++) begin
         if (c[i]) begin
            s = s ^ rotl_cw(PARITY_POLY, i);
         end
      end
   end

   assign error = |s;

endmodule

// File: rtl/cpe_retry_ctrl.sv
// ---------------------------------------------------------------------------
// cpe_retry_ctrl
// Check-and-retry controller downstream of the codeword detector. A codeword
// is registered, its syndrome registered, and the result is either delivered
// or a recompute is requested from upstream. Once MAX_RETRY retries of the
// same transaction have been spent, the codeword is delivered with out_fatal.
//
// Parameters:
//   MAX_RETRY  retries allowed per transaction before a fatal delivery (0..15)
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   err_count  saturating count of nonzero syndromes (only with CPE_ERR_COUNT_EN)
//   bus        cpe_retry_ctrl_if.slave handshake bundle
// Build option:
//   CPE_ERR_COUNT_EN  adds the err_count port and its 8-bit saturating counter
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | in_ready=1, waiting for a codeword
// CHECK | detector evaluates cw_q, syndrome and error flag are registered
// EVAL  | choose clean delivery, retry, or fatal delivery
// RETRY | retry_req=1 for one cycle, then back to IDLE for the resend
// OUT   | out_valid=1, payload held until out_ready
// ---------------------------------------------------------------------------
module cpe_retry_ctrl
   import cpe_pkg::*;
#(
   parameter int MAX_RETRY = 3
)
(
   input  logic                clk,
   input  logic                rst,
`ifdef CPE_ERR_COUNT_EN
   output logic [ERRCNT_W-1:0] err_count,
`endif
   cpe_retry_ctrl_if.slave     bus
);

   localparam logic [RETRY_W-1:0] MAX_Q = RETRY_W'(MAX_RETRY);

   state_t              state;
   logic [CW_W-1:0]     cw_q;
   logic [CW_W-1:0]     syn_q;
   logic                err_q;
   logic [RETRY_W-1:0]  retry_cnt;
   logic                fatal_q;
   logic                in_ready_q;
   logic                retry_req_q;
   logic                out_valid_q;

   logic [CW_W-1:0]     det_s;
   logic                det_err;

   detector u_detector (
      .c     (cw_q),
      .s     (det_s),
      .error (det_err)
   );

   // All handshake outputs are flops so retry_req and out_valid are glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cw_q        <= '0;
         syn_q       <= '0;
         err_q       <= 1'b0;
         retry_cnt   <= '0;
         fatal_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         retry_req_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         retry_req_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  cw_q       <= bus.in_cw;
                  fatal_q    <= 1'b0;
                  in_ready_q <= 1'b0;
                  state      <= CHECK;
               end
            end
            CHECK: begin
               syn_q <= det_s;
               err_q <= det_err;
               state <= EVAL;
            end
            EVAL: begin
               if (!err_q) begin
                  fatal_q     <= 1'b0;
                  out_valid_q <= 1'b1;
                  state       <= OUT;
               end else if (retry_cnt < MAX_Q) begin
                  retry_cnt   <= retry_cnt + 1'b1;
                  retry_req_q <= 1'b1;
                  state       <= RETRY;
               end else begin
                  fatal_q     <= 1'b1;
                  out_valid_q <= 1'b1;
                  state       <= OUT;
               end
            end
            RETRY: begin
               // retry_cnt is kept: the resend belongs to the same transaction
               in_ready_q <= 1'b1;
               state      <= IDLE;
            end
            OUT: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  retry_cnt   <= '0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

`ifdef CPE_ERR_COUNT_EN
   logic [ERRCNT_W-1:0] err_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else if (state == CHECK && det_err && err_cnt_q != {ERRCNT_W{1'b1}}) begin
         err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   assign err_count = err_cnt_q;
`endif

   assign bus.in_ready     = in_ready_q;
   assign bus.retry_req    = retry_req_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_cw       = cw_q;
   assign bus.out_fatal    = fatal_q;
   assign bus.out_syndrome = syn_q;

endmodule

// File: tb/tb_cpe_retry_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpe_retry_ctrl
// Self-checking bench for cpe_retry_ctrl. Expected deliveries are queued when
// a transaction is driven and compared when the DUT hands a result over.
// Build with CPE_ERR_COUNT_EN to also exercise err_count and its saturation.
// ---------------------------------------------------------------------------
module tb_cpe_retry_ctrl;
   import cpe_pkg::*;

   localparam int MAXR = 3;

   typedef struct packed {
      logic [CW_W-1:0] cw;
      logic            fatal;
      logic [CW_W-1:0] syn;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   cpe_retry_ctrl_if bus ();

`ifdef CPE_ERR_COUNT_EN
   logic [ERRCNT_W-1:0] err_count;
`endif

   cpe_retry_ctrl #(.MAX_RETRY(MAXR)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef CPE_ERR_COUNT_EN
      .err_count (err_count),
`endif
      .bus       (bus)
   );

   exp_t sb[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_bad = 0;
   int   retry_cycles = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference syndrome: schoolbook product c(x)*h(x), exponents folded mod 15.
   function automatic logic [CW_W-1:0] model_syn(input logic [CW_W-1:0] c);
      logic [CW_W-1:0] h;
      logic [CW_W-1:0] s;
      h = 15'h00D1;
      s = '0;
      for (int i = 0; i < CW_W; i++)
         for (int j = 0; j < CW_W; j++)
            if (c[i] && h[j]) s[(i + j) % CW_W] = ~s[(i + j) % CW_W];
      return s;
   endfunction

   // Monitor on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.retry_req) retry_cycles++;
         if (bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               chk("out_cw",    32'(bus.out_cw),       32'(mon_e.cw));
               chk("out_fatal", 32'(bus.out_fatal),    32'(mon_e.fatal));
               chk("out_syn",   32'(bus.out_syndrome), 32'(mon_e.syn));
            end
         end
      end
   end

   // All drivers run at posedge + 1.
   task automatic send(input logic [CW_W-1:0] cw);
      int t;
      t = 0;
      while (!bus.in_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_cw    = cw;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (!bus.out_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic run_clean(input logic [CW_W-1:0] cw);
      int cyc;
      int r0;
      r0 = retry_cycles;
      sb.push_back(exp_t'{cw: cw, fatal: 1'b0, syn: model_syn(cw)});
      send(cw);
      wait_out(cyc);
      chk("clean_lat", 32'(cyc), 32'd2);
      @(posedge clk); #1;
      chk("clean_in_ready", 32'(bus.in_ready), 32'd1);
      chk("clean_retries", 32'(retry_cycles - r0), 32'd0);
   endtask

   task automatic run_fatal(input logic [CW_W-1:0] cw, input logic [CW_W-1:0] syn);
      int cyc;
      int r0;
      r0 = retry_cycles;
      for (int k = 0; k < MAXR; k++) send(cw);
      sb.push_back(exp_t'{cw: cw, fatal: 1'b1, syn: syn});
      send(cw);
      wait_out(cyc);
      chk("fatal_lat", 32'(cyc), 32'd2);
      @(posedge clk); #1;
      chk("fatal_retries", 32'(retry_cycles - r0), 32'(MAXR));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int r0;
      logic [CW_W-1:0] clean_tab [3];
      clean_tab[0] = 15'h01D1;
      clean_tab[1] = 15'h0E88;
      clean_tab[2] = 15'h0F59;

      bus.in_valid  = 1'b0;
      bus.in_cw     = '0;
      bus.out_ready = 1'b1;

      // Reset values, visible while rst is held
      #2 rst = 1'b1;
      #1;
      chk("rst_in_ready",  32'(bus.in_ready),     32'd1);
      chk("rst_retry_req", 32'(bus.retry_req),    32'd0);
      chk("rst_out_valid", 32'(bus.out_valid),    32'd0);
      chk("rst_out_fatal", 32'(bus.out_fatal),    32'd0);
      chk("rst_out_cw",    32'(bus.out_cw),       32'd0);
      chk("rst_out_syn",   32'(bus.out_syndrome), 32'd0);
`ifdef CPE_ERR_COUNT_EN
      chk("rst_err_count", 32'(err_count), 32'd0);
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Clean codewords: all-zero plus nonzero members of the code
      run_clean(15'h0000);
      for (int i = 0; i < 3; i++) run_clean(clean_tab[i]);

      // Single-bit error then clean resend
      r0 = retry_cycles;
      send(15'h0001);
      @(posedge clk); #1;
      chk("err_t1_retry", 32'(bus.retry_req), 32'd0);
      @(posedge clk); #1;
      chk("err_t2_retry", 32'(bus.retry_req), 32'd1);
      chk("err_t2_ready", 32'(bus.in_ready),  32'd0);
      @(posedge clk); #1;
      chk("err_t3_retry", 32'(bus.retry_req), 32'd0);
      chk("err_t3_ready", 32'(bus.in_ready),  32'd1);
      chk("err_pulses",   32'(retry_cycles - r0), 32'd1);
`ifdef CPE_ERR_COUNT_EN
      chk("err_count_1", 32'(err_count), 32'd1);
`endif
      run_clean(15'h0000);

      // Reset while in RETRY
      send(15'h0001);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_retry", 32'(bus.retry_req), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_retry", 32'(bus.retry_req), 32'd0);
      chk("mid_rst_ready", 32'(bus.in_ready),  32'd1);
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
`ifdef CPE_ERR_COUNT_EN
      chk("mid_rst_errcnt", 32'(err_count), 32'd0);
`endif
      @(posedge clk); #1 rst = 1'b0;
      r0 = retry_cycles;
      repeat (10) begin
         @(posedge clk); #1;
         chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
      end
      chk("post_rst_retry", 32'(retry_cycles - r0), 32'd0);

      // Persistent error with backpressure on the fatal delivery
      r0 = retry_cycles;
      for (int k = 0; k < MAXR; k++) send(15'h0001);
      bus.out_ready = 1'b0;
      sb.push_back(exp_t'{cw: 15'h0001, fatal: 1'b1, syn: 15'h00D1});
      send(15'h0001);
      wait_out(cyc);
      chk("bp_lat", 32'(cyc), 32'd2);
      chk("bp_retries", 32'(retry_cycles - r0), 32'(MAXR));
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_ready", 32'(bus.in_ready),  32'd0);
         chk("bp_cw",    32'(bus.out_cw),    32'h0001);
         chk("bp_fatal", 32'(bus.out_fatal), 32'd1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_ready", 32'(bus.in_ready),  32'd1);
      chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
`ifdef CPE_ERR_COUNT_EN
      chk("err_count_4", 32'(err_count), 32'd4);
`endif

      // Retry budget restored after a fatal delivery
      run_fatal(15'h4000, model_syn(15'h4000));
      run_clean(15'h01D1);

`ifdef CPE_ERR_COUNT_EN
      // 75 fatal transactions add 300 erroneous checks on top of 8
      for (int n = 0; n < 75; n++) begin
         logic [CW_W-1:0] cw;
         cw = CW_W'(1) << (n % CW_W);
         run_fatal(cw, model_syn(cw));
      end
      chk("err_count_sat", 32'(err_count), 32'd255);
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
